rrc_fir_dec: RTL and testbench

//  Parametrised symmetric root-raised-cosine FIR with optional decimation, for the ADC I/Q sample path.

---
 rtl/rrc_fir_dec.sv | 148 ++++++++++++++
 tb/tb_rrc_fir_dec.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rrc_fir_dec.sv
// Symmetric root-raised-cosine FIR with runtime coefficients, integer decimation,
// round-half-up output scaling and sticky saturation. Fixed 3-clock latency.
module rrc_fir_dec #(
  parameter int WIDTH     = 7,
  parameter int COEF_W    = 9,
  parameter int NTAP      = 33,
  parameter int DEC       = 1,
  parameter int OUT_SHIFT = 7
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clr,
  input  logic                               in_valid,
  input  logic signed [WIDTH-1:0]            data_in,
  input  logic                               coef_we,
  input  logic [$clog2((NTAP+1)/2)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]           coef_data,
  output logic                               out_valid,
  output logic signed [WIDTH-1:0]            data_out,
  output logic                               sat_flag
);

  localparam int NH    = (NTAP + 1) / 2;
  localparam int PREW  = WIDTH + 1;
  localparam int PRODW = PREW + COEF_W;
  // One guard bit above the accumulator keeps the rounding add from wrapping.
  localparam int SUMW  = PRODW + $clog2(NH) + 1;
  localparam int PHW   = (DEC > 1) ? $clog2(DEC) : 1;

  localparam logic signed [SUMW-1:0] RND  = (OUT_SHIFT == 0) ? '0 : SUMW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [SUMW-1:0] MAXV = SUMW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [SUMW-1:0] MINV = ~MAXV;

  logic signed [WIDTH-1:0]  dline_q [NTAP];
  logic signed [COEF_W-1:0] coef_q  [NH];
  logic signed [PREW-1:0]   pre_d   [NH];
  logic signed [PREW-1:0]   pre_q   [NH];
  logic signed [PRODW-1:0]  prod_d  [NH];
  logic signed [PRODW-1:0]  prod_q  [NH];
  logic [PHW-1:0]           phase_q;
  logic                     tok0_q, tok1_q, tok2_q;
  logic                     accept;
  logic signed [SUMW-1:0]   acc, shifted;
  logic signed [WIDTH-1:0]  out_d;
  logic                     sat;

  assign accept = in_valid && !clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) dline_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NTAP; i++) dline_q[i] <= '0;
    end else if (in_valid) begin
      dline_q[0] <= data_in;
      for (int i = 1; i < NTAP; i++) dline_q[i] <= dline_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NH; i++) coef_q[i] <= '0;
      coef_q[NH-1] <= COEF_W'(1 << (COEF_W - 2));
    end else if (coef_we && (32'(coef_addr) < NH)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
    end else if (clr) begin
      phase_q <= '0;
    end else if (accept) begin
      phase_q <= (phase_q == PHW'(DEC - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NH - 1; i++) begin
      pre_d[i] = PREW'(dline_q[i]) + PREW'(dline_q[NTAP-1-i]);
    end
    pre_d[NH-1] = PREW'(dline_q[NH-1]);
    for (int i = 0; i < NH; i++) begin
      prod_d[i] = PRODW'(pre_q[i]) * PRODW'(coef_q[i]);
    end
  end

  always_comb begin
    acc = RND;
    for (int i = 0; i < NH; i++) acc = acc + SUMW'(prod_q[i]);
    shifted = acc >>> OUT_SHIFT;
    sat     = 1'b0;
    out_d   = WIDTH'(shifted);
    if (shifted > MAXV) begin
      sat   = 1'b1;
      out_d = WIDTH'(MAXV);
    end else if (shifted < MINV) begin
      sat   = 1'b1;
      out_d = WIDTH'(MINV);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NH; i++) begin
        pre_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      tok0_q <= 1'b0;
      tok1_q <= 1'b0;
      tok2_q <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < NH; i++) begin
        pre_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      tok0_q <= 1'b0;
      tok1_q <= 1'b0;
      tok2_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      prod_q <= prod_d;
      tok0_q <= accept && (phase_q == '0);
      tok1_q <= tok0_q;
      tok2_q <= tok1_q;
    end
  end

  // data_out holds its last value across clr; only reset zeroes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= tok2_q;
      if (tok2_q) begin
        data_out <= out_d;
        if (sat) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rrc_fir_dec.sv
// Directed bench for rrc_fir_dec: impulse, constant, saturation, clr, decimation,
// gapped input against a direct-form reference, and mid-stream reset.
module tb_rrc_fir_dec;
  localparam int W  = 7;
  localparam int CW = 9;
  localparam int NT = 33;
  localparam int NH = 17;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic coef_we = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic [4:0] coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic out_valid, sat_flag, ov2, sf2;
  logic signed [W-1:0] data_out, do2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accq[$];
  int outq[$];
  int out2[$];
  int hc[NH];
  int xs[40];
  int acc2[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rrc_fir_dec #(.WIDTH(W), .COEF_W(CW), .NTAP(NT), .DEC(1), .OUT_SHIFT(7)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
  );

  rrc_fir_dec #(.WIDTH(W), .COEF_W(CW), .NTAP(NT), .DEC(2), .OUT_SHIFT(7)) dut2 (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .data_in(data_in),
    .coef_we(1'b0), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov2), .data_out(do2), .sat_flag(sf2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Edge index of each accepted sample, consumed by the matching output pulse.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) accq.delete();
    else if (clr) accq.delete();
    else if (in_valid) accq.push_back(cyc);
  end

  always @(negedge clk) begin
    if (out_valid) begin
      check("ovalid_has_input", int'(accq.size() != 0), 1);
      if (accq.size() != 0) check("latency", cyc - 1 - accq.pop_front(), 3);
      outq.push_back(int'(data_out));
    end
    if (ov2) out2.push_back(cyc - 1);
  end

  task automatic push(input int v);
    in_valid = 1'b1;
    data_in  = W'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = CW'(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Direct-form convolution over the full 33-tap symmetric response.
  function automatic int model(input int n);
    int a;
    a = 64;
    for (int t = 0; t < NT; t++) begin
      if (n - t >= 0) a += hc[(t < NH) ? t : NT - 1 - t] * xs[n - t];
    end
    a = a >>> 7;
    if (a > 63) a = 63;
    if (a < -64) a = -64;
    return a;
  endfunction

  task automatic t_impulse(input string tg);
    outq.delete();
    push(10);
    repeat (40) push(0);
    idle(6);
    check({tg, "_count"}, outq.size(), 41);
    for (int i = 0; i < 41; i++) check($sformatf("%s_y%0d", tg, i), outq[i], (i == 16) ? 10 : 0);
  endtask

  task automatic t_model_run(input string tg, input bit gaps);
    pulse_clr();
    idle(4);
    outq.delete();
    for (int i = 0; i < 40; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      push(xs[i]);
    end
    idle(6);
    check({tg, "_count"}, outq.size(), 40);
    for (int i = 0; i < 40; i++) check($sformatf("%s_y%0d", tg, i), outq[i], model(i));
  endtask

  initial begin
    @(negedge clk);
    check("rst_dout", int'(data_out), 0);
    check("rst_ovalid", int'(out_valid), 0);
    check("rst_sat", int'(sat_flag), 0);
    rstn = 1'b1;
    idle(2);

    // T1: default coefs are a centre-tap pass-through delayed by 16 samples
    t_impulse("t1");

    // T2: all coefs 8, constant +5
    for (int a = 0; a < NH; a++) wcoef(a, 8);
    idle(3);
    outq.delete();
    repeat (40) push(5);
    idle(6);
    check("t2_count", outq.size(), 40);
    check("t2_y0", outq[0], 0);
    check("t2_y16", outq[16], 5);
    for (int i = 32; i < 40; i++) check($sformatf("t2_y%0d", i), outq[i], 10);
    check("t2_sat", int'(sat_flag), 0);

    // T3: saturation both ways, then clr drops its concurrent sample
    outq.delete();
    repeat (40) push(63);
    idle(6);
    check("t3_pos", outq[39], 63);
    check("t3_sat_set", int'(sat_flag), 1);
    outq.delete();
    repeat (40) push(-64);
    idle(6);
    check("t3_neg", outq[39], -64);
    check("t3_sat_sticky", int'(sat_flag), 1);
    outq.delete();
    clr = 1'b1;
    in_valid = 1'b1;
    data_in = W'(50);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    check("t3_clr_sat", int'(sat_flag), 0);
    check("t3_clr_hold", int'(data_out), -64);
    push(40);
    repeat (5) push(0);
    idle(6);
    check("t3_post_count", outq.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_post_y%0d", i), outq[i], 3);

    // T4: DEC=2 emits on accepted samples 0,2,4,6,8
    pulse_clr();
    idle(4);
    out2.delete();
    for (int i = 0; i < 10; i++) begin
      acc2[i] = cyc;
      push(i + 1);
      idle(i % 3);
    end
    idle(6);
    check("t4_count", out2.size(), 5);
    for (int j = 0; j < 5; j++) check($sformatf("t4_edge%0d", j), out2[j], acc2[2*j] + 3);

    // T5: asymmetric-valued coefs, random data, with and without gaps
    for (int a = 0; a < NH; a++) begin
      hc[a] = a * 9 - 60;
      wcoef(a, hc[a]);
    end
    idle(3);
    for (int i = 0; i < 40; i++) xs[i] = $urandom_range(0, 127) - 64;
    t_model_run("t5_nogap", 1'b0);
    t_model_run("t5_gap", 1'b1);

    // T6: reset mid-stream, then default response restored
    for (int i = 0; i < 8; i++) push(i * 5 - 20);
    in_valid = 1'b1;
    data_in = W'(30);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_dout", int'(data_out), 0);
    check("t6_ovalid", int'(out_valid), 0);
    check("t6_sat", int'(sat_flag), 0);
    @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    outq.delete();
    rstn = 1'b1;
    idle(5);
    check("t6_quiet", outq.size(), 0);
    t_impulse("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
